// File: rtl/controlador_cabine.sv
// Elevator car controller: timed floor-by-floor travel and door
// open/dwell/close sequencing with obstruction reopen.
module controlador_cabine #(
  parameter int CICLOS_ANDAR     = 4,
  parameter int CICLOS_PORTA     = 6,
  parameter int CICLOS_PORTA_MOV = 2
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [1:0] proximo_andar,
  input  logic       pedido_andar_atual,
  input  logic       obstaculo,
  output logic [1:0] andar_atual,
  output logic       movimento_elevador,
  output logic       indicador_porta_aberta,
  output logic       porta_fechada,
  output logic       em_movimento
);

  typedef enum logic [2:0] {
    OCIOSO,
    MOVENDO,
    ABRINDO,
    PORTA_ABERTA,
    FECHANDO
  } estado_t;

  localparam logic [7:0] FIM_ANDAR = 8'(CICLOS_ANDAR - 1);
  localparam logic [7:0] FIM_PORTA = 8'(CICLOS_PORTA - 1);
  localparam logic [7:0] FIM_MOV   = 8'(CICLOS_PORTA_MOV - 1);

  estado_t    estado;
  logic [7:0] cnt;
  logic [2:0] flags;

  // Output flags {door open, door closed, moving} for a given state,
  // loaded together with the state so outputs stay registered.
  function automatic logic [2:0] saidas(estado_t e);
    logic [2:0] s;
    s = 3'b010;
    case (e)
      OCIOSO:       s = 3'b010;
      MOVENDO:      s = 3'b011;
      ABRINDO:      s = 3'b000;
      PORTA_ABERTA: s = 3'b100;
      FECHANDO:     s = 3'b000;
      default:      s = 3'b010;
    endcase
    return s;
  endfunction

  assign {indicador_porta_aberta, porta_fechada, em_movimento} = flags;

  // Car FSM: state, shared phase counter, floor, direction, flags.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado             <= OCIOSO;
      cnt                <= 8'd0;
      andar_atual        <= 2'd0;
      movimento_elevador <= 1'b1;
      flags              <= 3'b010;
    end else begin
      case (estado)
        OCIOSO: begin
          if (pedido_andar_atual) begin
            estado <= ABRINDO;
            cnt    <= 8'd0;
            flags  <= saidas(ABRINDO);
          end else if (proximo_andar != andar_atual) begin
            movimento_elevador <= (proximo_andar > andar_atual);
            estado <= MOVENDO;
            cnt    <= 8'd0;
            flags  <= saidas(MOVENDO);
          end
        end
        MOVENDO: begin
          if (cnt == FIM_ANDAR) begin
            if (movimento_elevador && andar_atual != 2'd3)
              andar_atual <= andar_atual + 2'd1;
            else if (!movimento_elevador && andar_atual != 2'd0)
              andar_atual <= andar_atual - 2'd1;
            estado <= OCIOSO;
            cnt    <= 8'd0;
            flags  <= saidas(OCIOSO);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ABRINDO: begin
          if (cnt == FIM_MOV) begin
            estado <= PORTA_ABERTA;
            cnt    <= 8'd0;
            flags  <= saidas(PORTA_ABERTA);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PORTA_ABERTA: begin
          if (obstaculo) begin
            cnt <= 8'd0;
          end else if (cnt == FIM_PORTA) begin
            estado <= FECHANDO;
            cnt    <= 8'd0;
            flags  <= saidas(FECHANDO);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FECHANDO: begin
          if (obstaculo) begin
            estado <= ABRINDO;
            cnt    <= 8'd0;
            flags  <= saidas(ABRINDO);
          end else if (cnt == FIM_MOV) begin
            estado <= OCIOSO;
            cnt    <= 8'd0;
            flags  <= saidas(OCIOSO);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          estado <= OCIOSO;
          cnt    <= 8'd0;
          flags  <= saidas(OCIOSO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_cabine.sv
// Scoreboard bench for controlador_cabine: floor arrivals and door
// episodes are queued by the stimulus and checked by monitors.
module tb_controlador_cabine;

  logic       clock_in;
  logic       reset_n;
  logic [1:0] proximo_andar;
  logic       pedido_andar_atual;
  logic       obstaculo;
  logic [1:0] andar_atual;
  logic       movimento_elevador;
  logic       indicador_porta_aberta;
  logic       porta_fechada;
  logic       em_movimento;

  controlador_cabine dut (
    .clock_in              (clock_in),
    .reset_n               (reset_n),
    .proximo_andar         (proximo_andar),
    .pedido_andar_atual    (pedido_andar_atual),
    .obstaculo             (obstaculo),
    .andar_atual           (andar_atual),
    .movimento_elevador    (movimento_elevador),
    .indicador_porta_aberta(indicador_porta_aberta),
    .porta_fechada         (porta_fechada),
    .em_movimento          (em_movimento)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic       dir;
    logic [1:0] floor;
    logic [7:0] gap;
  } floor_exp_t;

  typedef struct packed {
    int open_len;
    int ind_total;
    int ind_run;
  } door_exp_t;

  floor_exp_t floor_q[$];
  door_exp_t  door_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor monitor: every change of andar_atual pops one expectation.
  initial begin
    int prev;
    int last;
    int cyc;
    floor_exp_t e;
    prev = 0;
    last = 0;
    cyc  = 0;
    forever begin
      @(negedge clock_in);
      cyc++;
      if (mon_en && int'(andar_atual) != prev) begin
        if (floor_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL floor_unexpected: got %0d, none queued",
                   andar_atual);
        end else begin
          e = floor_q.pop_front();
          check("floor", int'(andar_atual), int'(e.floor));
          check("dir", int'(movimento_elevador), int'(e.dir));
          if (e.gap != 8'd0)
            check("floor_gap", cyc - last, int'(e.gap));
        end
        last = cyc;
      end
      prev = int'(andar_atual);
    end
  end

  // Door monitor: measures each door-not-closed episode.
  initial begin
    int open_len;
    int ind_total;
    int run;
    int last_run;
    bit prev_ind;
    door_exp_t d;
    open_len  = 0;
    ind_total = 0;
    run       = 0;
    last_run  = 0;
    prev_ind  = 1'b0;
    forever begin
      @(negedge clock_in);
      if (!mon_en) begin
        open_len  = 0;
        ind_total = 0;
        run       = 0;
        last_run  = 0;
        prev_ind  = 1'b0;
      end else if (!porta_fechada) begin
        open_len++;
        check("still_door_open", int'(em_movimento), 0);
        if (indicador_porta_aberta) begin
          ind_total++;
          run      = prev_ind ? run + 1 : 1;
          last_run = run;
        end
        prev_ind = indicador_porta_aberta;
      end else if (open_len > 0) begin
        if (door_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL door_unexpected: len %0d, none queued",
                   open_len);
        end else begin
          d = door_q.pop_front();
          check("door_open_len", open_len, d.open_len);
          check("door_ind_total", ind_total, d.ind_total);
          check("door_ind_run", last_run, d.ind_run);
        end
        open_len  = 0;
        ind_total = 0;
        run       = 0;
        last_run  = 0;
        prev_ind  = 1'b0;
      end
    end
  end

  task automatic pulse_pedido();
    @(negedge clock_in);
    pedido_andar_atual = 1'b1;
    @(negedge clock_in);
    pedido_andar_atual = 1'b0;
  endtask

  // Stimulus.
  initial begin
    reset_n            = 1'b0;
    proximo_andar      = 2'd0;
    pedido_andar_atual = 1'b0;
    obstaculo          = 1'b0;
    repeat (3) @(negedge clock_in);
    check("rst_andar", int'(andar_atual), 0);
    check("rst_dir", int'(movimento_elevador), 1);
    check("rst_ind", int'(indicador_porta_aberta), 0);
    check("rst_fechada", int'(porta_fechada), 1);
    check("rst_mov", int'(em_movimento), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Idle with no requests: {andar, fechada, em_mov, dir} constant.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_in);
      check("idle_outs",
            int'({andar_atual, porta_fechada, em_movimento,
                  movimento_elevador}), 5'b00_1_0_1);
    end

    // Travel up to floor 3.
    floor_q.push_back('{dir: 1'b1, floor: 2'd1, gap: 8'd0});
    floor_q.push_back('{dir: 1'b1, floor: 2'd2, gap: 8'd5});
    floor_q.push_back('{dir: 1'b1, floor: 2'd3, gap: 8'd5});
    proximo_andar = 2'd3;
    @(negedge clock_in);
    check("start_mov", int'(em_movimento), 1);
    for (int i = 0; i < 40 && andar_atual != 2'd3; i++)
      @(negedge clock_in);
    check("reach_3", int'(andar_atual), 3);
    repeat (10) @(negedge clock_in);
    check("stay_3", int'(andar_atual), 3);
    check("stay_3_mov", int'(em_movimento), 0);

    // Travel down to floor 1.
    floor_q.push_back('{dir: 1'b0, floor: 2'd2, gap: 8'd0});
    floor_q.push_back('{dir: 1'b0, floor: 2'd1, gap: 8'd5});
    proximo_andar = 2'd1;
    for (int i = 0; i < 40 && andar_atual != 2'd1; i++)
      @(negedge clock_in);
    check("reach_1", int'(andar_atual), 1);
    repeat (3) @(negedge clock_in);
    check("dir_down", int'(movimento_elevador), 0);

    // Plain door service: 2 + 6 + 2.
    door_q.push_back('{open_len: 10, ind_total: 6, ind_run: 6});
    pulse_pedido();
    repeat (14) @(negedge clock_in);

    // Obstacle on dwell cycle index 4: 4 + 1 + 6 = 11 dwell.
    door_q.push_back('{open_len: 15, ind_total: 11, ind_run: 11});
    pulse_pedido();
    for (int i = 0; i < 10 && !indicador_porta_aberta; i++)
      @(negedge clock_in);
    check("open_a", int'(indicador_porta_aberta), 1);
    repeat (4) @(negedge clock_in);
    obstaculo = 1'b1;
    @(negedge clock_in);
    obstaculo = 1'b0;
    repeat (20) @(negedge clock_in);

    // Obstacle in first closing cycle: reopen and full dwell.
    door_q.push_back('{open_len: 19, ind_total: 12, ind_run: 6});
    pulse_pedido();
    for (int i = 0; i < 10 && !indicador_porta_aberta; i++)
      @(negedge clock_in);
    check("open_b", int'(indicador_porta_aberta), 1);
    for (int i = 0; i < 12 && indicador_porta_aberta; i++)
      @(negedge clock_in);
    check("closing_b", int'(porta_fechada), 0);
    obstaculo = 1'b1;
    @(negedge clock_in);
    obstaculo = 1'b0;
    repeat (25) @(negedge clock_in);
    check("door_q_empty", door_q.size(), 0);
    check("floor_q_empty", floor_q.size(), 0);

    // Asynchronous reset while travelling 1 -> 2.
    proximo_andar = 2'd3;
    repeat (2) @(negedge clock_in);
    check("travel_before_rst", int'(em_movimento), 1);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_andar", int'(andar_atual), 0);
    check("arst_mov", int'(em_movimento), 0);
    check("arst_fechada", int'(porta_fechada), 1);
    check("arst_ind", int'(indicador_porta_aberta), 0);
    check("arst_dir", int'(movimento_elevador), 1);
    proximo_andar = 2'd0;
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
